// File: rtl/sblock_cfg_if.sv
// Handshake/bus bundle between the bitstream source (master) and the
// Sblock configuration loader (slave).
interface sblock_cfg_if #(
  parameter int N_BLOCKS = 4,
  parameter int FRAME_W  = 18
);
  logic                start;
  logic                abort;
  logic                cfg_bit;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [N_BLOCKS-1:0] wr_en;
  logic [FRAME_W-1:0]  bits;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, abort, cfg_bit, cfg_valid,
    input  cfg_ready, wr_en, bits, busy, done, err
  );

  modport slave (
    input  start, abort, cfg_bit, cfg_valid,
    output cfg_ready, wr_en, bits, busy, done, err
  );
endinterface

// File: rtl/sblock_cfg_loader.sv
// Bit-serial configuration loader: deserialises parity-protected frames and
// issues one-hot write strobes with a shared config word to the Sblock array.
module sblock_cfg_loader #(
  parameter int N_BLOCKS = 4,
  parameter int FRAME_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  sblock_cfg_if.slave bus
);
  localparam int IDX_W = $clog2(N_BLOCKS) + 1;
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, PAR, WRITE, DONE} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [FRAME_W-1:0]  shreg_reg;
  logic                par_reg;
  logic                cfg_ready_reg;
  logic [N_BLOCKS-1:0] wr_en_reg;
  logic [FRAME_W-1:0]  bits_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;

  logic                beat;
  logic                last_blk;
  logic                par_ok;
  logic [N_BLOCKS-1:0] idx_onehot;

  assign beat     = bus.cfg_valid & cfg_ready_reg;
  assign last_blk = (idx_reg == IDX_W'(N_BLOCKS - 1));
  // Running XOR of the data bits plus the parity bit itself must be zero.
  assign par_ok   = ~(par_reg ^ bus.cfg_bit);

  genvar gi;
  generate
    for (gi = 0; gi < N_BLOCKS; gi++) begin : g_dec
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      par_reg       <= 1'b0;
      cfg_ready_reg <= 1'b0;
      wr_en_reg     <= '0;
      bits_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else if (state_reg != IDLE && bus.abort) begin
      // err is deliberately left untouched so the host can see earlier bad frames.
      state_reg     <= IDLE;
      cfg_ready_reg <= 1'b0;
      wr_en_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg     <= SHIFT;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            par_reg       <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            cfg_ready_reg <= 1'b1;
          end
        end
        SHIFT: begin
          if (beat) begin
            shreg_reg <= {shreg_reg[FRAME_W-2:0], bus.cfg_bit};
            par_reg   <= par_reg ^ bus.cfg_bit;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(FRAME_W - 1)) begin
              state_reg <= PAR;
            end
          end
        end
        PAR: begin
          if (beat) begin
            if (par_ok) begin
              state_reg     <= WRITE;
              cfg_ready_reg <= 1'b0;
              bits_reg      <= shreg_reg;
              wr_en_reg     <= idx_onehot;
            end else begin
              err_reg <= 1'b1;
              if (last_blk) begin
                state_reg     <= DONE;
                cfg_ready_reg <= 1'b0;
                done_reg      <= 1'b1;
              end else begin
                state_reg <= SHIFT;
                idx_reg   <= idx_reg + IDX_W'(1);
                cnt_reg   <= '0;
                par_reg   <= 1'b0;
              end
            end
          end
        end
        WRITE: begin
          wr_en_reg <= '0;
          if (last_blk) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg     <= SHIFT;
            idx_reg       <= idx_reg + IDX_W'(1);
            cnt_reg       <= '0;
            par_reg       <= 1'b0;
            cfg_ready_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.wr_en     = wr_en_reg;
  assign bus.bits      = bits_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
endmodule
